seg7_multi_driver: RTL and testbench
====================================

Name: seg7_multi_driver

Overview:
Parametrised N-digit hex display driver for the board's active-low 7-segment displays. It latches a packed multi-digit value with per-digit blank and blink masks and optional leading-zero suppression. It drives either N static digit outputs or one time-multiplexed digit bus with an active-low one-hot digit select. It sits between datapath/status logic and the HEX display pins.

Parameters:
N_DIGITS, 6, number of hex digits; legal range 1..8.
BLINK_DIV, 25000000, clock cycles per blink half-period; must be at least 2.
SCAN_DIV, 50000, clock cycles each digit is held in scan mode; must be at least 1.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset_n  input  1  synchronous, active-low reset.
load  input  1  capture strobe for value, blank_mask, blink_mask and lz_suppress.
value  input  4*N_DIGITS  packed digits; digit i is value[4i+3:4i], and digit 0 is the rightmost.
blank_mask  input  N_DIGITS  1 forces digit i off.
blink_mask  input  N_DIGITS  1 makes digit i blink.
lz_suppress  input  1  1 blanks leading zero digits.
scan_mode  input  1  0 selects static outputs; 1 selects multiplexed outputs.
leds  output  7*N_DIGITS  static segments, active low; digit i is leds[7i+6:7i].
scan_leds  output  7  multiplexed segments, active low.
scan_sel  output  N_DIGITS  active-low one-hot digit select.

Behaviour:
- Reset (reset_n=0 at an edge):
  - shadow value = 0, shadow blank = all ones, shadow blink = 0, shadow lz = 0.
  - Blink counter and blink phase = 0; scan counter and scan index = 0.
  - leds = all ones, scan_leds = 7'h7F, scan_sel = all ones.
  - load is ignored while reset_n=0.
- Load: load=1 at edge t writes all four shadow registers at edge t. The outputs reflect the new data after edge t+1, because all outputs are registered. load may be held high; a new capture then happens every cycle.
- Font (bits 6..0, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, B=03, C=46, D=21, E=06, F=0E. Off = 7F.
- Leading-zero blank for digit i (i>0): shadow lz=1 and digits i..N_DIGITS-1 are all zero. Digit 0 is never suppressed.
- Effective blank for digit i: shadow blank[i] OR (shadow blink[i] AND blink_phase) OR the leading-zero blank for digit i. A blanked digit outputs 7F.
- Blink counter:
  - Free-running over 0..BLINK_DIV-1 and unaffected by load.
  - On wrap, blink_phase toggles; phase 1 is the blanked half.
  - A load coinciding with a toggle applies both effects.
- Static mode (scan_mode=0):
  - leds carries every digit pattern.
  - scan_leds = 7F and scan_sel = all ones.
  - The scan counter and scan index are held at 0.
- Scan mode (scan_mode=1):
  - leds = all ones.
  - The scan counter runs over 0..SCAN_DIV-1. On wrap the index increments, and N_DIGITS-1 wraps to 0. SCAN_DIV=1 advances every cycle.
  - scan_sel = ~(1<<index) and scan_leds = pattern of digit index, both registered from the current index. A blanked digit still asserts its select but drives 7F.
- Mode change: takes effect at the next edge's registered outputs. Entering scan mode starts at index 0 with a full SCAN_DIV dwell.
- Reset mid-operation returns every register to its reset value at that edge. The blink and scan sequences restart from 0.
- N_DIGITS=1: scan_sel is constantly 0 in scan mode, and leading-zero suppression never blanks.

Decomposition:
- Package seg7_pkg holds:
  - SEG_OFF = 7'h7F;
  - the 16-entry font constant array;
  - the hex_to_seg function;
  - a parameter-check macro or assertion helper for the legal ranges.
- Sub-module seg7_font: a combinational 4-bit to 7-bit decode, instantiated once per digit from a generate loop.
- The top level owns the shadow registers, blink and scan counters, blank logic and output registers.

Test Plan:
Bench parameters: N_DIGITS=4, BLINK_DIV=4, SCAN_DIV=2.
1. reset_n=0 for 2 cycles, then 1 -> leds = 28'hFFFFFFF, scan_sel = 4'b1111, scan_leds = 7F.
2. load=1 for one cycle with value=16'h12AF, masks 0, lz=0 -> one cycle later, digits 3..0 = 79, 24, 08, 0E.
3. lz=1 with value=16'h0030 -> digits 7F, 7F, 30, 40. Then value=16'h0000 -> 7F, 7F, 7F, 40.
4. blink_mask=4'b0001 with value=16'h1234 -> digit 0 alternates 19 (4 cycles) then 7F (4 cycles); digits 3..1 stay steady at 79, 24, 30.
5. scan_mode=1 with value=16'h1234 -> scan_sel steps 1110, 1101, 1011, 0111, 1110, each for 2 cycles; scan_leds = 19, 30, 24, 79 in step; leds all ones.
6. reset_n=0 at index 2 of scan mode -> next edge: scan_sel = 1111, scan_leds = 7F, and all blanks set. After release and a reload, the scan restarts at index 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multi-digit 7-segment driver.
package seg7_pkg;

    // All segments dark (segments are active low)
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex font, bit 6 = segment g ... bit 0 = segment a, active low
    localparam logic [6:0] FONT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        return FONT[h];
    endfunction

    // Legal parameter ranges, checked at elaboration by the top level
    function automatic bit params_ok(input int n_digits, input int blink_div, input int scan_div);
        return (n_digits >= 1) && (n_digits <= 8) && (blink_div >= 2) && (scan_div >= 1);
    endfunction

endpackage

// File: rtl/seg7_font.sv
// Combinational hex digit to active-low segment decode.
module seg7_font
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(hex);

endmodule

// File: rtl/seg7_multi_driver.sv
// N-digit hex display driver: shadow registers, blink/scan timing,
// per-digit blanking and registered static or multiplexed outputs.
module seg7_multi_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS  = 6,
    parameter int BLINK_DIV = 25000000,
    parameter int SCAN_DIV  = 50000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     blank_mask,
    input  logic [N_DIGITS-1:0]     blink_mask,
    input  logic                    lz_suppress,
    input  logic                    scan_mode,
    output logic [7*N_DIGITS-1:0]   leds,
    output logic [6:0]              scan_leds,
    output logic [N_DIGITS-1:0]     scan_sel
);

    if (!params_ok(N_DIGITS, BLINK_DIV, SCAN_DIV)) begin : g_bad_params
        $fatal(1, "seg7_multi_driver: illegal N_DIGITS/BLINK_DIV/SCAN_DIV");
    end

    localparam int BW    = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam int SW    = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int IW    = (N_DIGITS  > 1) ? $clog2(N_DIGITS)  : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    logic [4*N_DIGITS-1:0]      sh_val;
    logic [N_DIGITS-1:0]        sh_blank;
    logic [N_DIGITS-1:0]        sh_blink;
    logic                       sh_lz;

    logic [BW-1:0]              bcnt;
    logic                       bphase;
    logic [SW-1:0]              scnt;
    logic [IW-1:0]              sidx;

    logic [N_DIGITS-1:0][6:0]   raw;
    logic [N_DIGITS-1:0][6:0]   pat;
    logic [N_DIGITS-1:0]        lz_blank;
    logic [N_DIGITS-1:0]        sel_onehot;

    // Shadow registers capture the display request on load
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sh_val   <= '0;
            sh_blank <= '1;
            sh_blink <= '0;
            sh_lz    <= 1'b0;
        end else if (load) begin
            sh_val   <= value;
            sh_blank <= blank_mask;
            sh_blink <= blink_mask;
            sh_lz    <= lz_suppress;
        end
    end

    // Free-running blink timebase; phase 1 is the dark half
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bcnt   <= '0;
            bphase <= 1'b0;
        end else if (bcnt == BLINK_LAST) begin
            bcnt   <= '0;
            bphase <= ~bphase;
        end else begin
            bcnt   <= bcnt + 1'b1;
        end
    end

    // Scan dwell counter and digit index; parked at 0 outside scan mode so
    // entering scan mode always begins on digit 0 with a full dwell
    always_ff @(posedge clk) begin
        if (!reset_n || !scan_mode) begin
            scnt <= '0;
            sidx <= '0;
        end else if (scnt == SCAN_LAST) begin
            scnt <= '0;
            sidx <= (sidx == IDX_LAST) ? '0 : sidx + 1'b1;
        end else begin
            scnt <= scnt + 1'b1;
        end
    end

    // Per-digit decode and blanking
    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        seg7_font u_font (
            .hex (sh_val[4*i +: 4]),
            .seg (raw[i])
        );

        // A digit is a leading zero when it and everything left of it is zero;
        // the rightmost digit always shows
        if (i == 0) begin : g_lz0
            assign lz_blank[i] = 1'b0;
        end else begin : g_lzn
            assign lz_blank[i] = sh_lz && (sh_val[4*N_DIGITS-1:4*i] == '0);
        end

        assign pat[i] = (sh_blank[i] || (sh_blink[i] && bphase) || lz_blank[i]) ? SEG_OFF : raw[i];
    end

    // One-hot select for the digit currently being scanned
    always_comb begin
        sel_onehot       = '0;
        sel_onehot[sidx] = 1'b1;
    end

    // Registered outputs: static drives every digit, scan drives one at a time
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            leds      <= '1;
            scan_leds <= SEG_OFF;
            scan_sel  <= '1;
        end else if (scan_mode) begin
            leds      <= '1;
            scan_leds <= pat[sidx];
            scan_sel  <= ~sel_onehot;
        end else begin
            leds      <= pat;
            scan_leds <= SEG_OFF;
            scan_sel  <= '1;
        end
    end

endmodule

// File: tb/tb_seg7_multi_driver.sv
// Directed scoreboard bench for seg7_multi_driver (4 digits, fast dividers).
module tb_seg7_multi_driver;

    localparam int N  = 4;
    localparam int BD = 4;
    localparam int SD = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    blank_mask = '0;
    logic [3:0]    blink_mask = '0;
    logic          lz_suppress = 1'b0;
    logic          scan_mode = 1'b0;
    logic [27:0]   leds;
    logic [6:0]    scan_leds;
    logic [3:0]    scan_sel;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;   // edges since the last reset edge

    typedef struct {
        string       tag;
        logic [27:0] leds;
        logic [6:0]  sl;
        logic [3:0]  ss;
    } exp_t;

    exp_t sb[$];

    seg7_multi_driver #(
        .N_DIGITS  (N),
        .BLINK_DIV (BD),
        .SCAN_DIV  (SD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (load),
        .value       (value),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .lz_suppress (lz_suppress),
        .scan_mode   (scan_mode),
        .leds        (leds),
        .scan_leds   (scan_leds),
        .scan_sel    (scan_sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n) ecnt <= 0;
        else          ecnt <= ecnt + 1;
    end

    function automatic logic [6:0] font(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [27:0] mk_leds(input logic [15:0] v, input logic [3:0] off);
        logic [27:0] r;
        for (int i = 0; i < N; i++)
            r[7*i +: 7] = off[i] ? 7'h7F : font(v[4*i +: 4]);
        return r;
    endfunction

    task automatic push(input string tag, input logic [27:0] l, input logic [6:0] sl, input logic [3:0] ss);
        exp_t e;
        e.tag = tag; e.leds = l; e.sl = sl; e.ss = ss;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $error("FAIL scoreboard_empty got=0 exp=1");
        end else begin
            e = sb.pop_front();
            total++;
            assert (leds === e.leds) else begin
                bad++; $error("FAIL %s leds got=%h exp=%h", e.tag, leds, e.leds);
            end
            total++;
            assert (scan_leds === e.sl) else begin
                bad++; $error("FAIL %s scan_leds got=%h exp=%h", e.tag, scan_leds, e.sl);
            end
            total++;
            assert (scan_sel === e.ss) else begin
                bad++; $error("FAIL %s scan_sel got=%b exp=%b", e.tag, scan_sel, e.ss);
            end
        end
    endtask

    initial begin
        logic [3:0]  sel;
        logic [6:0]  sl;
        int          idx;
        logic        ph;
        logic [3:0]  one;

        // 1. reset, with a load attempt that must be ignored
        reset_n = 1'b0; load = 1'b1; value = 16'h1234; blank_mask = '0;
        push("reset", '1, 7'h7F, 4'b1111);
        tick(); tick();
        check();
        load = 1'b0; reset_n = 1'b1;
        push("load_in_reset", '1, 7'h7F, 4'b1111);
        tick();
        check();

        // 2. basic load and one-cycle output latency
        value = 16'h12AF; blank_mask = '0; blink_mask = '0; lz_suppress = 1'b0; load = 1'b1;
        push("pre_latency", '1, 7'h7F, 4'b1111);
        tick();
        check();
        load = 1'b0;
        push("load_12AF", mk_leds(16'h12AF, 4'b0000), 7'h7F, 4'b1111);
        tick();
        check();

        // 3. leading-zero suppression
        value = 16'h0030; lz_suppress = 1'b1; load = 1'b1;
        tick(); load = 1'b0;
        push("lz_0030", mk_leds(16'h0030, 4'b1100), 7'h7F, 4'b1111);
        tick();
        check();
        value = 16'h0000; load = 1'b1;
        tick(); load = 1'b0;
        push("lz_0000", mk_leds(16'h0000, 4'b1110), 7'h7F, 4'b1111);
        tick();
        check();

        // blank mask overrides a non-zero digit
        value = 16'h1234; lz_suppress = 1'b0; blank_mask = 4'b0100; load = 1'b1;
        tick(); load = 1'b0;
        push("blank_d2", mk_leds(16'h1234, 4'b0100), 7'h7F, 4'b1111);
        tick();
        check();

        // 4. blink on digit 0; phase follows the edge count since reset
        value = 16'h1234; blank_mask = '0; blink_mask = 4'b0001; load = 1'b1;
        tick(); load = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            ph = ((((ecnt - 1) / BD) % 2) != 0);
            push("blink", mk_leds(16'h1234, {3'b000, ph}), 7'h7F, 4'b1111);
            check();
        end

        // 5. scan mode, two cycles per digit
        blink_mask = '0; load = 1'b1;
        tick(); load = 1'b0;
        tick();
        scan_mode = 1'b1;
        for (int k = 0; k < 13; k++) begin
            tick();
            idx = (k / SD) % N;
            one = 4'b0001 << idx;
            sel = ~one;
            sl  = font(value[4*idx +: 4]);
            push("scan", '1, sl, sel);
            check();
        end

        // 6. reset while digit 2 is scanned, then reload and restart at 0
        reset_n = 1'b0;
        push("scan_reset", '1, 7'h7F, 4'b1111);
        tick();
        check();
        reset_n = 1'b1; load = 1'b1; value = 16'h1234; blank_mask = '0;
        push("scan_rel_blank", '1, 7'h7F, 4'b1110);
        tick();
        check();
        load = 1'b0;
        push("scan_restart0", '1, 7'h19, 4'b1110);
        tick(); check();
        push("scan_restart1a", '1, 7'h30, 4'b1101);
        tick(); check();
        push("scan_restart1b", '1, 7'h30, 4'b1101);
        tick(); check();
        push("scan_restart2", '1, 7'h24, 4'b1011);
        tick(); check();

        // back to static mode
        scan_mode = 1'b0;
        push("static_again", mk_leds(16'h1234, 4'b0000), 7'h7F, 4'b1111);
        tick();
        check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
